// File: rtl/neuron_input_streamer.sv
// neuron_input_streamer: register-file loader that streams signed (w, x) pairs with valid/ready/last
module neuron_input_streamer #(
    parameter int N  = 10,
    parameter int DW = 16,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic          start,
    output logic [DW-1:0] out_w,
    output logic [DW-1:0] out_x,
    output logic [AW-1:0] out_idx,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [DW-1:0] out_bias,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] w_mem [2**AW];
    logic [DW-1:0] x_mem [2**AW];
    logic          wr_bad, wr_ok, hs, load;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_w, rd_x;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state == IDLE   ? (start ? STREAM : IDLE) :
                    state == STREAM ? (hs && out_last ? DONE : STREAM) : IDLE;
    end
    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        out_valid = state == STREAM;
        out_last  = out_valid && out_idx == AW'(N - 1);
    end
    // A write in the same IDLE cycle as start is forwarded so the first pair sees it
    always_comb begin
        wr_bad = wr_en && (wr_sel == 2'd3 || (!wr_sel[1] && {1'b0, wr_addr} >= (AW+1)'(N)) || busy);
        wr_ok  = wr_en && !wr_bad;
        hs     = out_valid && out_ready;
        load   = (state == IDLE && start) || (hs && !out_last);
        rd_idx = state == IDLE ? '0 : out_idx + AW'(1);
        rd_w   = wr_ok && wr_sel == 2'd0 && wr_addr == rd_idx ? wr_data : w_mem[rd_idx];
        rd_x   = wr_ok && wr_sel == 2'd1 && wr_addr == rd_idx ? wr_data : x_mem[rd_idx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err   <= 1'b0;
            out_idx  <= '0;
            out_w    <= '0;
            out_x    <= '0;
            out_bias <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                w_mem[i] <= '0;
                x_mem[i] <= '0;
            end
        end else begin
            wr_err <= wr_bad;
            if (wr_ok && wr_sel == 2'd0) w_mem[wr_addr] <= wr_data;
            if (wr_ok && wr_sel == 2'd1) x_mem[wr_addr] <= wr_data;
            if (wr_ok && wr_sel == 2'd2) out_bias <= wr_data;
            if (load) begin
                out_idx <= rd_idx;
                out_w   <= rd_w;
                out_x   <= rd_x;
            end
        end
    end
endmodule

// File: tb/tb_neuron_input_streamer.sv
// tb_neuron_input_streamer: directed and randomized checks against an array model of the register files
module tb_neuron_input_streamer;
    localparam int N = 10;
    logic        clk = 0, rst = 1;
    logic        wr_en = 0, start = 0, out_ready = 0, wr_en1 = 0, start1 = 0;
    logic [1:0]  wr_sel = 0;
    logic [3:0]  wr_addr = 0;
    logic [15:0] wr_data = 0;
    logic        wr_err, out_valid, out_last, busy, done;
    logic [15:0] out_w, out_x, out_bias;
    logic [3:0]  out_idx;
    logic        wr_err1, out_valid1, out_last1, busy1, done1;
    logic [15:0] out_w1, out_x1, out_bias1;
    logic        out_idx1;
    logic [15:0] mw [N], mx [N], mbias;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    neuron_input_streamer #(.N(N), .DW(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_err(wr_err), .start(start), .out_w(out_w), .out_x(out_x),
        .out_idx(out_idx), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .out_bias(out_bias), .busy(busy), .done(done));

    neuron_input_streamer #(.N(1), .DW(16)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_sel(wr_sel), .wr_addr(1'b0),
        .wr_data(wr_data), .wr_err(wr_err1), .start(start1), .out_w(out_w1), .out_x(out_x1),
        .out_idx(out_idx1), .out_valid(out_valid1), .out_last(out_last1), .out_ready(out_ready),
        .out_bias(out_bias1), .busy(busy1), .done(done1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input int addr, input logic [15:0] data);
        logic bad;
        bad = sel == 2'd3 || (sel < 2 && addr >= N);
        wr_en = 1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 0;
        chk("wr_err", wr_err, bad);
        if (!bad && sel == 0) mw[addr] = data;
        if (!bad && sel == 1) mx[addr] = data;
        if (!bad && sel == 2) mbias = data;
        chk("bias_after_wr", out_bias, mbias);
    endtask

    // mode: 0 ready high, 1 ready 1,0,0 repeating, 2 random ready
    task automatic run_stream(input int mode, input int inj, input int rst_at,
                              input logic ws_en, input logic [15:0] ws_data);
        int idx = 0, cyc = 0;
        start = 1;
        if (ws_en) begin
            wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = ws_data; mw[0] = ws_data;
        end
        @(negedge clk);
        start = 0; wr_en = 0;
        while (idx < N && cyc < 500) begin
            if (idx == rst_at) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_w", out_w, 0);
                for (int i = 0; i < N; i++) begin
                    mw[i] = 0; mx[i] = 0;
                end
                mbias = 0;
                @(negedge clk);
                chk("rst_no_done", done, 0);
                return;
            end
            chk("valid", out_valid, 1);
            chk("idx", out_idx, idx);
            chk("w", out_w, mw[idx]);
            chk("x", out_x, mx[idx]);
            chk("last", out_last, idx == N - 1);
            chk("done_mid", done, 0);
            chk("busy", busy, 1);
            chk("bias", out_bias, mbias);
            chk("err_mid", wr_err, inj >= 0 && cyc == inj + 1);
            start = 0; wr_en = 0;
            if (cyc == inj) begin
                start = 1; wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 16'h7FFF;
            end
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom);
            if (out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        start = 0; wr_en = 0; out_ready = 0;
        chk("handshakes", idx, N);
        chk("end_valid", out_valid, 0);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        chk("no_restart", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mw[i] = 0; mx[i] = 0;
        end
        mbias = 0;
        repeat (2) @(negedge clk);
        chk("r_valid", out_valid, 0);
        chk("r_last", out_last, 0);
        chk("r_idx", out_idx, 0);
        chk("r_w", out_w, 0);
        chk("r_x", out_x, 0);
        chk("r_bias", out_bias, 0);
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_err", wr_err, 0);
        chk("r1_valid", out_valid1, 0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            wr(0, i, 16'(i + 1));
            wr(1, i, 16'(-(i + 1)));
        end
        wr(2, 0, 16'd7);
        run_stream(0, -1, -1, 0, 0);
        run_stream(1, -1, -1, 0, 0);
        run_stream(0, 3, -1, 0, 0);
        run_stream(0, -1, -1, 0, 0);
        wr(0, 12, 16'h5555);
        wr(3, 0, 16'h5555);
        run_stream(2, -1, -1, 0, 0);
        run_stream(0, -1, -1, 1, 16'h1234);
        for (int i = 0; i < N; i++) begin
            wr(0, i, 16'($urandom));
            wr(1, i, 16'($urandom));
        end
        wr(2, 0, 16'($urandom));
        run_stream(2, -1, -1, 0, 0);
        run_stream(1, -1, -1, 0, 0);
        run_stream(0, -1, 4, 0, 0);
        run_stream(0, -1, -1, 0, 0);
        wr_en1 = 1; wr_sel = 0; wr_data = 16'h8000;
        @(negedge clk);
        wr_sel = 1; wr_data = 16'h7FFF;
        @(negedge clk);
        wr_en1 = 0;
        chk("n1_err", wr_err1, 0);
        start1 = 1; out_ready = 1;
        @(negedge clk);
        start1 = 0;
        chk("n1_valid", out_valid1, 1);
        chk("n1_last", out_last1, 1);
        chk("n1_w", out_w1, 16'h8000);
        chk("n1_x", out_x1, 16'h7FFF);
        chk("n1_idx", out_idx1, 0);
        chk("n1_done_early", done1, 0);
        @(negedge clk);
        chk("n1_done", done1, 1);
        chk("n1_valid_off", out_valid1, 0);
        @(negedge clk);
        chk("n1_done_clear", done1, 0);
        chk("n1_busy", busy1, 0);
        out_ready = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/neuron_input_streamer.md
Name: neuron_input_streamer

Overview:
- Producer side of the neuron operand interface.
- Software or a loader writes weights, input activations and a bias into local register files through a write port.
- On start, the block walks an index counter and streams signed (w, x) pairs with valid/ready/last to a downstream MAC/ReLU neuron, and holds the bias stable for the activation stage.
- One instance feeds one neuron of a layer.

Parameters:
- N, 10, number of (w, x) pairs per neuron evaluation; legal range 1..1024.
- DW, 16, signed operand width for weights, inputs and bias.
- AW, $clog2(N) (min 1), index/address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write strobe
- wr_sel  in  2  target: 0=weight file, 1=input file, 2=bias, 3=reserved
- wr_addr  in  AW  file index; ignored for bias
- wr_data  in  DW  signed write data
- wr_err  out  1  one-cycle pulse on a rejected write
- start  in  1  one-cycle request to stream one evaluation
- out_w  out  DW  signed weight of the current pair
- out_x  out  DW  signed input of the current pair
- out_idx  out  AW  index of the current pair
- out_valid  out  1  pair on out_w/out_x is valid
- out_last  out  1  current pair is index N-1
- out_ready  in  1  downstream accepts the pair this cycle
- out_bias  out  DW  bias register, continuously driven
- busy  out  1  high in STREAM and DONE
- done  out  1  one-cycle pulse after the last pair is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - State becomes IDLE.
  - out_valid, out_last, busy, done, wr_err = 0; out_idx = 0; out_w, out_x = 0; out_bias = 0.
  - Weight and input files are cleared to 0.
  - Reset mid-STREAM aborts the stream immediately; no done pulse is issued.
- Writes:
  - Accepted only in IDLE; each takes effect at the clock edge.
  - A write with wr_sel=3, wr_addr>=N for files, or issued while busy=1 is dropped, and wr_err=1 for the following cycle.
  - A write and a start in the same IDLE cycle: the write lands first, so the stream uses the new value.
- State machine (IDLE, STREAM, DONE):
  - IDLE: start=1 -> STREAM. The counter loads 0, out_valid=1 and the pair at index 0 is presented the next cycle, giving one cycle of start-to-first-valid latency.
  - STREAM: a handshake occurs when out_valid&&out_ready.
    - On a handshake with idx<N-1: idx increments and the next pair appears the following cycle, so back-to-back throughput is one pair per clock.
    - On a handshake with idx=N-1: go to DONE and drop out_valid.
  - STREAM stall: out_ready=0 holds out_w, out_x, out_idx and out_last stable, with out_valid kept at 1.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start while busy=1 is ignored (not queued).
- Datapath:
  - out_w and out_x are registered reads of file[idx].
  - out_last = out_valid && (out_idx == N-1).
  - N=1: the first pair already has out_last=1.
- Index counter:
  - Never wraps inside a stream.
  - Returns to 0 on entry to STREAM.
- Bias:
  - out_bias updates the cycle after a bias write.
  - Unchanged by streaming; the downstream stage may sample it at any time.
- File contents persist across evaluations until rewritten or reset.
- Signed two's-complement values pass through unmodified; the block does no arithmetic.

Test Plan:
- N=10: write weights 1..10 and inputs -1..-10, bias=7; start with out_ready tied high -> out_valid the cycle after start; pairs (1,-1)…(10,-10) on consecutive cycles with idx 0..9; out_last only on idx 9; done pulses once, one cycle after the last handshake; out_bias=7 throughout.
- Same data, out_ready toggling 1,0,0,1,… -> each pair held stable while stalled; exactly 10 handshakes in order; done fires after the 10th handshake.
- During STREAM: write weight[0]=0x7FFF and assert start -> write dropped with a wr_err pulse; start ignored; streamed weight[0] stays 1; a second evaluation afterwards also shows 1.
- In IDLE: write to addr 12 (N=10) and write with wr_sel=3 -> both dropped with a wr_err pulse; file contents unchanged.
- Assert rst at idx 4 mid-stream -> next cycle out_valid=0, busy=0, no done pulse; a restream outputs zeros, as the files were cleared.
- N=1, weight=-32768, input=32767: start -> a single pair with out_last=1 and exact signed values; done two cycles after start with out_ready high.
